// File: rtl/autoconfig_master.sv
// Zorro II AutoConfig master: walks the configuration chain, reads each board's
// ID nibbles, and places it in the memory or I/O pool or shuts it up.
module autoconfig_master #(
    parameter int unsigned MAX_BOARDS = 8,
    parameter logic [7:0]  MEM_START  = 8'h20,
    parameter logic [7:0]  MEM_END    = 8'hA0,
    parameter logic [7:0]  IO_START   = 8'hE9,
    parameter logic [7:0]  IO_END     = 8'hF0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    output logic        BUSY,
    output logic        DONE,
    output logic        BUS_REQ,
    output logic        BUS_RW,
    output logic [23:0] BUS_ADDR,
    output logic [7:0]  BUS_WDATA,
    input  logic        BUS_ACK,
    input  logic        BUS_ERR,
    input  logic [3:0]  BUS_RDATA,
    output logic        CFG_VALID,
    output logic [7:0]  CFG_BASE,
    output logic [7:0]  CFG_SIZE,
    output logic [15:0] CFG_MFG,
    output logic [7:0]  CFG_PROD,
    output logic        CFG_MEM,
    output logic [3:0]  BOARD_COUNT
);

    typedef enum logic [3:0] {
        IDLE, READ, DECODE, ALLOC, WR_LO, WR_HI, SHUTUP, NEXT, FINISH
    } state_t;

    state_t      state, state_nxt;
    logic [2:0]  nib_idx;
    logic [31:0] id_shift;      // {type, product, manufacturer} after assembly
    logic [7:0]  size;
    logic        is_mem;
    logic        shut;
    logic [7:0]  base;
    logic [8:0]  mem_ptr, io_ptr;

    logic        bus_done;
    logic        last_board;
    logic [7:0]  typ;
    logic [3:0]  nib_adj;
    logic [7:0]  rd_off;
    logic [7:0]  size_dec;
    logic [8:0]  pool_ptr, pool_start, pool_end, mask, aligned, base_c, top_c;
    logic        fits;

    assign typ        = id_shift[31:24];
    assign bus_done   = BUS_REQ & BUS_ACK;
    assign nib_adj    = (nib_idx < 3'd2) ? BUS_RDATA : ~BUS_RDATA;
    assign rd_off     = {3'b000, nib_idx[2], 1'b0, nib_idx[1:0], 1'b0};
    assign size_dec   = (typ[2:0] == 3'd0) ? 8'd128 : (8'd1 << (typ[2:0] - 3'd1));
    assign last_board = (32'(BOARD_COUNT) + 32'd1 == MAX_BOARDS);

    // Alignment is measured from the pool start, so a board as large as the
    // whole pool still fits at its bottom.
    always_comb begin
        pool_ptr   = is_mem ? mem_ptr : io_ptr;
        pool_start = {1'b0, is_mem ? MEM_START : IO_START};
        pool_end   = {1'b0, is_mem ? MEM_END : IO_END};
        mask       = {1'b0, size} - 9'd1;
        aligned    = ((pool_ptr - pool_start) + mask) & ~mask;
        base_c     = pool_start + aligned;
        top_c      = base_c + {1'b0, size};
        fits       = (top_c <= pool_end);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: state_nxt gets its default before the case so no path infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (START) state_nxt = READ;
            READ:    if (bus_done) begin
                         if (BUS_ERR)              state_nxt = FINISH;
                         else if (nib_idx == 3'd7) state_nxt = DECODE;
                     end
            DECODE:  state_nxt = (typ[7:6] != 2'b11 || typ == 8'hFF) ? FINISH : ALLOC;
            ALLOC:   state_nxt = fits ? WR_LO : SHUTUP;
            WR_LO:   if (bus_done) state_nxt = BUS_ERR ? FINISH : WR_HI;
            WR_HI:   if (bus_done) state_nxt = BUS_ERR ? FINISH : NEXT;
            SHUTUP:  if (bus_done) state_nxt = BUS_ERR ? FINISH : NEXT;
            NEXT:    state_nxt = last_board ? FINISH : READ;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            BUS_REQ     <= 1'b0;
            BUS_RW      <= 1'b1;
            BUS_ADDR    <= '0;
            BUS_WDATA   <= '0;
            CFG_VALID   <= 1'b0;
            CFG_BASE    <= '0;
            CFG_SIZE    <= '0;
            CFG_MFG     <= '0;
            CFG_PROD    <= '0;
            CFG_MEM     <= 1'b0;
            BOARD_COUNT <= '0;
            nib_idx     <= '0;
            id_shift    <= '0;
            size        <= '0;
            is_mem      <= 1'b0;
            shut        <= 1'b0;
            base        <= '0;
            mem_ptr     <= '0;
            io_ptr      <= '0;
        end else begin
            DONE      <= 1'b0;
            CFG_VALID <= 1'b0;
            // A new request is only raised while BUS_REQ is low, which
            // guarantees the idle cycle between bus cycles.
            if (bus_done) BUS_REQ <= 1'b0;
            case (state)
                IDLE: if (START) begin
                    BUSY        <= 1'b1;
                    BOARD_COUNT <= '0;
                    mem_ptr     <= {1'b0, MEM_START};
                    io_ptr      <= {1'b0, IO_START};
                    nib_idx     <= '0;
                end
                READ: begin
                    if (!BUS_REQ) begin
                        BUS_REQ  <= 1'b1;
                        BUS_RW   <= 1'b1;
                        BUS_ADDR <= {16'hE800, rd_off};
                    end else if (BUS_ACK && !BUS_ERR) begin
                        id_shift <= {id_shift[27:0], nib_adj};
                        nib_idx  <= nib_idx + 3'd1;
                    end
                end
                DECODE: begin
                    size   <= size_dec;
                    is_mem <= typ[5];
                end
                ALLOC: begin
                    base <= base_c[7:0];
                    shut <= !fits;
                    if (fits) begin
                        if (is_mem) mem_ptr <= top_c;
                        else        io_ptr  <= top_c;
                    end
                end
                WR_LO: if (!BUS_REQ) begin
                    BUS_REQ   <= 1'b1;
                    BUS_RW    <= 1'b0;
                    BUS_ADDR  <= 24'hE8004A;
                    BUS_WDATA <= {base[3:0], 4'h0};
                end
                WR_HI: if (!BUS_REQ) begin
                    BUS_REQ   <= 1'b1;
                    BUS_RW    <= 1'b0;
                    BUS_ADDR  <= 24'hE80048;
                    BUS_WDATA <= base;
                end
                SHUTUP: if (!BUS_REQ) begin
                    BUS_REQ   <= 1'b1;
                    BUS_RW    <= 1'b0;
                    BUS_ADDR  <= 24'hE8004C;
                    BUS_WDATA <= 8'h00;
                end
                NEXT: begin
                    CFG_VALID   <= 1'b1;
                    CFG_BASE    <= shut ? 8'h00 : base;
                    CFG_SIZE    <= size;
                    CFG_MFG     <= id_shift[15:0];
                    CFG_PROD    <= id_shift[23:16];
                    CFG_MEM     <= is_mem;
                    BOARD_COUNT <= BOARD_COUNT + 4'd1;
                end
                FINISH: begin
                    DONE <= 1'b1;
                    BUSY <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_autoconfig_master.sv
// Bench for autoconfig_master: a bus slave emulating a chain of boards, with
// scoreboards of expected config writes and CFG reports.
module tb_autoconfig_master;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        START;
    logic        BUSY, DONE;
    logic        BUS_REQ, BUS_RW;
    logic [23:0] BUS_ADDR;
    logic [7:0]  BUS_WDATA;
    logic        BUS_ACK, BUS_ERR;
    logic [3:0]  BUS_RDATA;
    logic        CFG_VALID;
    logic [7:0]  CFG_BASE, CFG_SIZE, CFG_PROD;
    logic [15:0] CFG_MFG;
    logic        CFG_MEM;
    logic [3:0]  BOARD_COUNT;

    autoconfig_master dut (
        .CLK(CLK), .RESET(RESET), .START(START), .BUSY(BUSY), .DONE(DONE),
        .BUS_REQ(BUS_REQ), .BUS_RW(BUS_RW), .BUS_ADDR(BUS_ADDR), .BUS_WDATA(BUS_WDATA),
        .BUS_ACK(BUS_ACK), .BUS_ERR(BUS_ERR), .BUS_RDATA(BUS_RDATA),
        .CFG_VALID(CFG_VALID), .CFG_BASE(CFG_BASE), .CFG_SIZE(CFG_SIZE),
        .CFG_MFG(CFG_MFG), .CFG_PROD(CFG_PROD), .CFG_MEM(CFG_MEM),
        .BOARD_COUNT(BOARD_COUNT)
    );

    initial forever #5 CLK = ~CLK;

    typedef struct packed {
        logic [7:0]  typ;
        logic [7:0]  prod;
        logic [15:0] mfg;
    } board_t;

    board_t      board_q[$];
    logic [31:0] exp_wr[$];     // {addr, data}
    logic [40:0] exp_cfg[$];    // {base, size, mfg, prod, mem}

    int          total = 0;
    int          bad   = 0;
    int          rd_idx = 0;
    bit          slave_en = 1'b1;
    bit          err_arm = 1'b0;
    logic [23:0] err_addr = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] rd_off(input int i);
        case (i)
            0: return 8'h00;  1: return 8'h02;  2: return 8'h04;  3: return 8'h06;
            4: return 8'h10;  5: return 8'h12;  6: return 8'h14;  default: return 8'h16;
        endcase
    endfunction

    // Raw bus nibble: type is returned as-is, the rest inverted; empty chain reads F.
    function automatic logic [3:0] board_nibble(input logic [7:0] off);
        board_t b;
        if (board_q.size() == 0) return 4'hF;
        b = board_q[0];
        case (off)
            8'h00:   return b.typ[7:4];
            8'h02:   return b.typ[3:0];
            8'h04:   return ~b.prod[7:4];
            8'h06:   return ~b.prod[3:0];
            8'h10:   return ~b.mfg[15:12];
            8'h12:   return ~b.mfg[11:8];
            8'h14:   return ~b.mfg[7:4];
            8'h16:   return ~b.mfg[3:0];
            default: return 4'hF;
        endcase
    endfunction

    task automatic add_board(input logic [7:0] typ, input logic [7:0] prod, input logic [15:0] mfg);
        board_t b;
        b.typ = typ; b.prod = prod; b.mfg = mfg;
        board_q.push_back(b);
    endtask

    task automatic exp_ok(input logic [7:0] base, input logic [7:0] size,
                          input logic [15:0] mfg, input logic [7:0] prod, input logic mem);
        exp_wr.push_back({24'hE8004A, base[3:0], 4'h0});
        exp_wr.push_back({24'hE80048, base});
        exp_cfg.push_back({base, size, mfg, prod, mem});
    endtask

    task automatic exp_shut(input logic [7:0] size, input logic [15:0] mfg,
                            input logic [7:0] prod, input logic mem);
        exp_wr.push_back({24'hE8004C, 8'h00});
        exp_cfg.push_back({8'h00, size, mfg, prod, mem});
    endtask

    // Bus slave: variable latency, checks request stability and the drop after ACK.
    int          wait_cnt = 0;
    int          lat = 0;
    bit          in_cycle = 1'b0;
    logic [32:0] held;
    logic [31:0] wr_item;

    initial begin
        BUS_ACK = 1'b0; BUS_ERR = 1'b0; BUS_RDATA = 4'h0;
        forever begin
            @(negedge CLK);
            if (slave_en) begin
                if (BUS_ACK) begin
                    BUS_ACK = 1'b0; BUS_ERR = 1'b0; in_cycle = 1'b0;
                    check("req_drop", 64'(BUS_REQ), 64'd0);
                end else if (BUS_REQ) begin
                    if (!in_cycle) begin
                        in_cycle = 1'b1; wait_cnt = 0;
                        lat = $urandom_range(0, 2);
                        held = {BUS_RW, BUS_ADDR, BUS_WDATA};
                    end
                    if (wait_cnt == lat) begin
                        if (lat > 0) check("req_stable", 64'({BUS_RW, BUS_ADDR, BUS_WDATA}), 64'(held));
                        if (BUS_RW) begin
                            check("rd_addr", 64'(BUS_ADDR), 64'({16'hE800, rd_off(rd_idx)}));
                            BUS_RDATA = board_nibble(BUS_ADDR[7:0]);
                            rd_idx = (rd_idx + 1) % 8;
                            if (err_arm && BUS_ADDR == err_addr) begin
                                BUS_ERR = 1'b1; err_arm = 1'b0;
                            end
                        end else begin
                            if (exp_wr.size() == 0) begin
                                check("wr_extra", 64'({BUS_ADDR, BUS_WDATA}), 64'hFFFF_FFFF);
                            end else begin
                                wr_item = exp_wr.pop_front();
                                check("wr", 64'({BUS_ADDR, BUS_WDATA}), 64'(wr_item));
                            end
                            if (err_arm && BUS_ADDR == err_addr) begin
                                BUS_ERR = 1'b1; err_arm = 1'b0;
                            end else if ((BUS_ADDR == 24'hE80048 || BUS_ADDR == 24'hE8004C)
                                         && board_q.size() != 0) begin
                                void'(board_q.pop_front());
                            end
                        end
                        BUS_ACK = 1'b1;
                    end else begin
                        wait_cnt++;
                    end
                end else begin
                    in_cycle = 1'b0;
                end
            end
        end
    end

    // CFG report monitor.
    logic [40:0] cfg_item;
    initial forever begin
        @(negedge CLK);
        if (CFG_VALID === 1'b1) begin
            if (exp_cfg.size() == 0) begin
                check("cfg_extra", 64'({CFG_BASE, CFG_SIZE, CFG_MFG, CFG_PROD, CFG_MEM}), 64'h1FF_FFFF_FFFF);
            end else begin
                cfg_item = exp_cfg.pop_front();
                check("cfg", 64'({CFG_BASE, CFG_SIZE, CFG_MFG, CFG_PROD, CFG_MEM}), 64'(cfg_item));
            end
        end
    end

    task automatic run_and_wait(input string tag, input int exp_count);
        int cyc;
        rd_idx = 0;
        @(negedge CLK); START = 1'b1;
        @(negedge CLK); START = 1'b0;
        check({tag, "_busy"}, 64'(BUSY), 64'd1);
        START = 1'b1;                       // must be ignored while busy
        @(negedge CLK); START = 1'b0;
        cyc = 0;
        while (DONE !== 1'b1 && cyc < 3000) begin
            @(negedge CLK);
            cyc++;
        end
        check({tag, "_done"}, 64'(DONE), 64'd1);
        check({tag, "_count"}, 64'(BOARD_COUNT), 64'(exp_count));
        check({tag, "_wr_left"}, 64'(exp_wr.size()), 64'd0);
        check({tag, "_cfg_left"}, 64'(exp_cfg.size()), 64'd0);
        @(negedge CLK);
        check({tag, "_end"}, 64'({BUSY, DONE}), 64'd0);
        exp_wr.delete();
        exp_cfg.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b0;
        START = 1'b0;
        #12;
        check("rst_bus", 64'({BUS_REQ, BUS_RW, BUS_ADDR, BUS_WDATA}), 64'({1'b0, 1'b1, 24'h0, 8'h0}));
        check("rst_ctl", 64'({BUSY, DONE, CFG_VALID, BOARD_COUNT}), 64'd0);
        check("rst_cfg", 64'({CFG_BASE, CFG_SIZE, CFG_MFG, CFG_PROD, CFG_MEM}), 64'd0);
        @(negedge CLK); RESET = 1'b1;

        // Single 8MB RAM board at the bottom of the memory pool.
        add_board(8'hE0, 8'h01, 16'h07DB);
        exp_ok(8'h20, 8'd128, 16'h07DB, 8'h01, 1'b1);
        run_and_wait("one_8mb", 1);
        repeat (3) @(negedge CLK);
        check("hold_cfg", 64'({CFG_BASE, CFG_SIZE, CFG_PROD}), 64'({8'h20, 8'd128, 8'h01}));
        check("hold_count", 64'(BOARD_COUNT), 64'd1);

        // 8MB RAM then a 64K I/O board.
        add_board(8'hE0, 8'h01, 16'h07DB);
        add_board(8'hC1, 8'h05, 16'h0202);
        exp_ok(8'h20, 8'd128, 16'h07DB, 8'h01, 1'b1);
        exp_ok(8'hE9, 8'd1, 16'h0202, 8'h05, 1'b0);
        run_and_wait("ram_io", 2);

        // Two 8MB RAM boards: the second no longer fits.
        add_board(8'hE0, 8'h01, 16'h07DB);
        add_board(8'hE0, 8'h02, 16'h07DB);
        exp_ok(8'h20, 8'd128, 16'h07DB, 8'h01, 1'b1);
        exp_shut(8'd128, 16'h07DB, 8'h02, 1'b1);
        run_and_wait("two_8mb", 2);

        // Alignment, independent pools, and the MAX_BOARDS limit (9th board untouched).
        add_board(8'hE1, 8'h10, 16'h1111);   // mem 64K  -> 20, ptr 21
        add_board(8'hC2, 8'h11, 16'h2222);   // io 128K  -> E9, ptr EB
        add_board(8'hE5, 8'h12, 16'h3333);   // mem 1MB  -> 30, ptr 40
        add_board(8'hE1, 8'h13, 16'h4444);   // mem 64K  -> 40, ptr 41
        add_board(8'hE0, 8'h14, 16'h5555);   // mem 8MB  -> shut up
        add_board(8'hC1, 8'h15, 16'h6666);   // io 64K   -> EB, ptr EC
        add_board(8'hC0, 8'h16, 16'h7777);   // io 8MB   -> shut up
        add_board(8'hE1, 8'h17, 16'h8888);   // mem 64K  -> 41
        add_board(8'hE1, 8'h18, 16'h9999);   // beyond the limit
        exp_ok(8'h20, 8'd1,   16'h1111, 8'h10, 1'b1);
        exp_ok(8'hE9, 8'd2,   16'h2222, 8'h11, 1'b0);
        exp_ok(8'h30, 8'd16,  16'h3333, 8'h12, 1'b1);
        exp_ok(8'h40, 8'd1,   16'h4444, 8'h13, 1'b1);
        exp_shut(     8'd128, 16'h5555, 8'h14, 1'b1);
        exp_ok(8'hEB, 8'd1,   16'h6666, 8'h15, 1'b0);
        exp_shut(     8'd128, 16'h7777, 8'h16, 1'b0);
        exp_ok(8'h41, 8'd1,   16'h8888, 8'h17, 1'b1);
        run_and_wait("pools_max", 8);
        check("left_on_bus", 64'(board_q.size()), 64'd1);
        board_q.delete();

        // Empty chain: type reads FF.
        run_and_wait("empty", 0);

        // Error on the high-byte write: no report for that board.
        add_board(8'hE0, 8'h01, 16'h07DB);
        err_addr = 24'hE80048; err_arm = 1'b1;
        exp_wr.push_back({24'hE8004A, 8'h00});
        exp_wr.push_back({24'hE80048, 8'h20});
        run_and_wait("err_wrhi", 0);
        board_q.delete();

        // Error during the ID reads: no writes at all.
        add_board(8'hE0, 8'h01, 16'h07DB);
        err_addr = 24'hE80004; err_arm = 1'b1;
        run_and_wait("err_read", 0);
        board_q.delete();
        err_arm = 1'b0;

        // Reset in the middle of a bus cycle, then a stray ACK while idle.
        add_board(8'hE1, 8'h21, 16'hABCD);
        rd_idx = 0;
        @(negedge CLK); START = 1'b1;
        @(negedge CLK); START = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge CLK); #1;
            if (BUS_REQ) break;
        end
        check("req_before_rst", 64'(BUS_REQ), 64'd1);
        RESET = 1'b0;
        #1;
        check("rst_async", 64'({BUS_REQ, BUS_RW, BUSY, BUS_ADDR}), 64'({1'b0, 1'b1, 1'b0, 24'h0}));
        @(negedge CLK); RESET = 1'b1;
        slave_en = 1'b0;
        @(negedge CLK); BUS_ACK = 1'b1; BUS_RDATA = 4'h0;
        @(negedge CLK); BUS_ACK = 1'b0;
        repeat (2) @(negedge CLK);
        slave_en = 1'b1;
        check("late_ack", 64'({BUSY, BUS_REQ, DONE, BOARD_COUNT}), 64'd0);
        exp_ok(8'h20, 8'd1, 16'hABCD, 8'h21, 1'b1);
        run_and_wait("after_rst", 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
